// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg: shared types, widths and protected register indices for the writeback scheduler
package regfile_ctrl_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 19;
  localparam logic [ADDR_W-1:0] ZERO_IDX = 5'd0;
  localparam logic [ADDR_W-1:0] PC_IDX = 5'd19;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} wb_sched_state_t;
  function automatic logic is_prot(input logic [ADDR_W-1:0] a);
    return a == ZERO_IDX || a == PC_IDX;
  endfunction
endpackage

// File: rtl/wb_queue_2w1r.sv
// wb_queue_2w1r: circular write queue with two ordered enqueue ports and one dequeue port
module wb_queue_2w1r
  import regfile_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enq0,
  input  wb_req_t                       req0,
  input  logic                          enq1,
  input  wb_req_t                       req1,
  input  logic                          deq,
  output wb_req_t                       head,
  output logic [CW-1:0]                 count,
  output logic [DEPTH-1:0]              ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr
);
  wb_req_t mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr1;
  // the younger request lands just behind the older one, or at wr_ptr if the older was not enqueued
  assign wr1 = wr_ptr + PW'(enq0);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(enq0) + PW'(enq1);
      rd_ptr <= rd_ptr + PW'(deq);
      count <= count + CW'(enq0) + CW'(enq1) - CW'(deq);
    end
  always_ff @(posedge clk) begin
    if (enq0) mem[wr_ptr] <= req0;
    if (enq1) mem[wr1] <= req1;
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off = PW'(i) - rd_ptr;
    assign ent_valid[i] = {1'b0, off} < count;
    assign ent_addr[i] = mem[i].addr;
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: arbitrates ALU/load writebacks onto the register-file write port in program order.
// Optional pending-write query comparators are built when REGFILE_PENDING_CHECK_EN is defined.
module regfile_wb_scheduler
  import regfile_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s1_valid,
  output logic              s1_ready,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              flush_req,
  output logic              flush_done,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  output logic              drop,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_hit1,
  output logic              chk_hit2
);
  wb_sched_state_t state, state_nx;
  wb_req_t head;
  logic [CW-1:0] count;
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic acc0, acc1, prot0, prot1, deq;
  assign s0_ready = state == IDLE && count <= CW'(DEPTH - 1);
  assign s1_ready = state == IDLE && count <= CW'(DEPTH - 2);
  assign acc0 = s0_valid && s0_ready;
  assign acc1 = s1_valid && s1_ready;
  assign prot0 = is_prot(s0_addr);
  assign prot1 = is_prot(s1_addr);
  assign deq = count != '0;
  assign flush_done = state == DONE;
  wb_queue_2w1r #(.DEPTH(DEPTH)) u_queue (
    .clk(clk),
    .reset(reset),
    .enq0(acc0 && !prot0),
    .req0('{addr: s0_addr, data: s0_data}),
    .enq1(acc1 && !prot1),
    .req1('{addr: s1_addr, data: s1_data}),
    .deq(deq),
    .head(head),
    .count(count),
    .ent_valid(ent_valid),
    .ent_addr(ent_addr)
  );
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (flush_req ? DRAIN : IDLE) :
               state == DRAIN ? ((count == '0 && !we3) ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      we3 <= 1'b0;
      a3 <= '0;
      wd3 <= '0;
      drop <= 1'b0;
    end else begin
      state <= state_nx;
      we3 <= deq;
      if (deq) begin
        a3 <= head.addr;
        wd3 <= head.data;
      end
      drop <= (acc0 && prot0) || (acc1 && prot1);
    end
`ifdef REGFILE_PENDING_CHECK_EN
  always_comb begin
    chk_hit1 = we3 && a3 == chk_addr1;
    chk_hit2 = we3 && a3 == chk_addr2;
    for (int i = 0; i < DEPTH; i++) begin
      chk_hit1 = chk_hit1 | (ent_valid[i] && ent_addr[i] == chk_addr1);
      chk_hit2 = chk_hit2 | (ent_valid[i] && ent_addr[i] == chk_addr2);
    end
    chk_hit1 = chk_hit1 && !is_prot(chk_addr1);
    chk_hit2 = chk_hit2 && !is_prot(chk_addr2);
  end
`else
  logic unused_chk;
  assign unused_chk = ^{chk_addr1, chk_addr2, ent_valid, ent_addr};
  assign chk_hit1 = 1'b0;
  assign chk_hit2 = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed and random stimulus checked against a queue-based reference model
module tb_regfile_wb_scheduler;
  import regfile_ctrl_pkg::*;
  logic clk = 0, reset = 1;
  logic s0_valid = 0, s1_valid = 0, flush_req = 0;
  logic [ADDR_W-1:0] s0_addr = 0, s1_addr = 0, chk_addr1 = 0, chk_addr2 = 0, a3;
  logic [DATA_W-1:0] s0_data = 0, s1_data = 0, wd3;
  logic s0_ready, s1_ready, flush_done, we3, drop, chk_hit1, chk_hit2;
  int n_chk = 0, n_fail = 0;
  // reference model: pending writes in acceptance order plus expected port values
  logic [ADDR_W+DATA_W-1:0] mq[$];
  int ms = 0;
  logic ew = 0, ed = 0;
  logic [ADDR_W-1:0] ea = 0;
  logic [DATA_W-1:0] ewd = 0;

  regfile_wb_scheduler #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
    .flush_req(flush_req), .flush_done(flush_done),
    .we3(we3), .a3(a3), .wd3(wd3), .drop(drop),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_hit1(chk_hit1), .chk_hit2(chk_hit2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic m_hit(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_PENDING_CHECK_EN
    if (a == 0 || a == 19) return 0;
    if (ew && ea == a) return 1;
    foreach (mq[i]) if (mq[i][ADDR_W+DATA_W-1:DATA_W] == a) return 1;
    return 0;
`else
    return a != a;
`endif
  endfunction

  task automatic m_clear();
    mq.delete();
    ms = 0; ew = 0; ed = 0; ea = 0; ewd = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".we3"}, 32'(we3), 32'(ew));
    chk({tag, ".a3"}, 32'(a3), 32'(ea));
    chk({tag, ".wd3"}, 32'(wd3), 32'(ewd));
    chk({tag, ".drop"}, 32'(drop), 32'(ed));
    chk({tag, ".flush_done"}, 32'(flush_done), 32'(ms == 2));
  endtask

  task automatic step(input logic v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                      input logic v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                      input logic fl, input string tag);
    int sz;
    logic r0, r1;
    @(negedge clk);
    s0_valid = v0; s0_addr = a0; s0_data = d0;
    s1_valid = v1; s1_addr = a1; s1_data = d1;
    flush_req = fl;
    chk_addr1 = 5'($urandom_range(0, 31));
    chk_addr2 = mq.size() > 0 ? mq[0][ADDR_W+DATA_W-1:DATA_W] : 5'($urandom_range(0, 31));
    #1;
    sz = mq.size();
    r0 = ms == 0 && sz <= 3;
    r1 = ms == 0 && sz <= 2;
    chk({tag, ".s0_ready"}, 32'(s0_ready), 32'(r0));
    chk({tag, ".s1_ready"}, 32'(s1_ready), 32'(r1));
    chk({tag, ".chk_hit1"}, 32'(chk_hit1), 32'(m_hit(chk_addr1)));
    chk({tag, ".chk_hit2"}, 32'(chk_hit2), 32'(m_hit(chk_addr2)));
    @(posedge clk);
    ms = ms == 0 ? (fl ? 1 : 0) : ms == 1 ? ((sz == 0 && !ew) ? 2 : 1) : 0;
    ew = sz > 0;
    if (sz > 0) {ea, ewd} = mq.pop_front();
    ed = 0;
    if (v0 && r0) begin
      if (a0 == 0 || a0 == 19) ed = 1; else mq.push_back({a0, d0});
    end
    if (v1 && r1) begin
      if (a1 == 0 || a1 == 19) ed = 1; else mq.push_back({a1, d1});
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input int k, input string tag);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    return 5'($urandom_range(1, 18));
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset.s0_ready", 32'(s0_ready), 1);
    chk("reset.s1_ready", 32'(s1_ready), 1);
    @(negedge clk);
    reset = 0;
    step(1, 3, 19'h1ABCD, 0, 0, 0, 0, "single");
    idle(2, "single_out");
    step(1, 5, 19'h11, 1, 5, 19'h22, 0, "dual");
    idle(3, "dual_out");
    step(1, 0, 19'h55, 1, 19, 19'h66, 0, "protected");
    idle(2, "prot_out");
    for (int i = 0; i < 8; i++)
      step(1, rand_addr(), 19'($urandom), 1, rand_addr(), 19'($urandom), 0, "backpressure");
    idle(6, "bp_drain");
    step(1, 7, 19'h7, 1, 8, 19'h8, 0, "fl_fill");
    step(1, 9, 19'h9, 0, 0, 0, 0, "fl_fill");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1, "flush");
    idle(3, "post_flush");
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), 5'($urandom_range(0, 31)), 19'($urandom),
           $urandom_range(0, 1), 5'($urandom_range(0, 31)), 19'($urandom),
           $urandom_range(0, 15) == 0, "random");
    idle(8, "rand_drain");
    step(1, 7, 19'h70, 1, 12, 19'h120, 1, "rst_fill");
    @(negedge clk);
    s0_valid = 0; s1_valid = 0;
    chk_addr1 = 7;
    #1;
    chk("rst.chk_hit1", 32'(chk_hit1), 32'(m_hit(7)));
    #1;
    reset = 1;
    m_clear();
    #1;
    check_outputs("rst_mid");
    chk("rst_mid.s0_ready", 32'(s0_ready), 1);
    @(negedge clk);
    reset = 0;
    flush_req = 0;
    idle(5, "rst_after");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
